// File: rtl/tff_mod_counter_pkg.sv
// Shared definitions for the T-flip-flop modulo counter: direction encoding,
// legal parameter bounds and the clog2 helper used to validate WIDTH/MODULUS.
package tff_mod_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    function automatic int clog2(input longint value);
        int     bits;
        longint span;
        bits = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit T flip-flop with synchronous active-low reset; toggles when t=1.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_mod_counter.sv
// Loadable up/down modulo counter built only from T flip-flop cells; every
// state change (reset, load, count) is expressed as T = Q ^ target.
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || MODULUS < 2 ||
            clog2(MODULUS) > WIDTH) begin : g_bad_params
            $error("tff_mod_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] t;
    logic             wrapped_next;

    always_comb begin
        target       = q;
        wrapped_next = wrapped;
        if (!rst_n) begin
            target       = '0;
            wrapped_next = 1'b0;
        end else if (!load_n) begin
            target       = (d > MAX_VAL) ? MAX_VAL : d;
            wrapped_next = 1'b0;
        end else if (en) begin
            if (up == DIR_UP) begin
                // >= also catches an out-of-range power-up value
                if (q >= MAX_VAL) begin
                    target       = '0;
                    wrapped_next = 1'b1;
                end else begin
                    target = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    target       = MAX_VAL;
                    wrapped_next = 1'b1;
                end else begin
                    target = q - WIDTH'(1);
                end
            end
        end
    end

    assign t  = q ^ target;
    assign tc = en & (((up == DIR_UP) & (q == MAX_VAL)) |
                      ((up == DIR_DN) & (q == '0)));

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            tff_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .t     (t[i]),
                .q     (q[i])
            );
        end
    endgenerate

    tff_cell u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (wrapped ^ wrapped_next),
        .q     (wrapped)
    );

endmodule

// File: tb/tb_tff_mod_counter.sv
// Self-checking bench for tff_mod_counter: vector table, directed corner
// sequences, randomized stimulus against an arithmetic model, and a cascade.
module tb_tff_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, load_n, en, up;
    logic [15:0] d;

    logic [3:0]  q4;
    logic        tc4, wr4;
    logic [7:0]  q8;
    logic        tc8, wr8;
    logic [15:0] q16;
    logic        tc16, wr16;

    logic        c_rst_n;
    logic [3:0]  lo_q, hi_q;
    logic        lo_tc, hi_tc, lo_wr, hi_wr;

    tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u4 (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .en(en), .up(up),
        .d(d[3:0]), .q(q4), .tc(tc4), .wrapped(wr4));

    tff_mod_counter #(.WIDTH(8), .MODULUS(200)) u8 (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .en(en), .up(up),
        .d(d[7:0]), .q(q8), .tc(tc8), .wrapped(wr8));

    tff_mod_counter #(.WIDTH(16), .MODULUS(65536)) u16 (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .en(en), .up(up),
        .d(d), .q(q16), .tc(tc16), .wrapped(wr16));

    tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rst_n(c_rst_n), .load_n(1'b1), .en(1'b1), .up(1'b1),
        .d(4'd0), .q(lo_q), .tc(lo_tc), .wrapped(lo_wr));

    tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rst_n(c_rst_n), .load_n(1'b1), .en(lo_tc), .up(1'b1),
        .d(4'd0), .q(hi_q), .tc(hi_tc), .wrapped(hi_wr));

    int checks   = 0;
    int failures = 0;

    int m4q = 0, m4w = 0, m8q = 0, m8w = 0, m16q = 0, m16w = 0;

    typedef struct {
        bit       r;
        bit       ld;
        bit       e;
        bit       u;
        int       dv;
        int       exp_q;
        int       exp_w;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int model_tc(input int qv, input bit e, input bit u, input int m);
        return (e && ((u && qv == m - 1) || (!u && qv == 0))) ? 1 : 0;
    endfunction

    task automatic model_step(inout int qv, inout int wv, input bit r, input bit ld,
                              input bit e, input bit u, input int dv, input int m);
        if (!r) begin
            qv = 0;
            wv = 0;
        end else if (!ld) begin
            qv = (dv > m - 1) ? m - 1 : dv;
            wv = 0;
        end else if (e) begin
            if (u) begin
                if (qv >= m - 1) begin
                    qv = 0;
                    wv = 1;
                end else begin
                    qv = qv + 1;
                end
            end else begin
                if (qv == 0) begin
                    qv = m - 1;
                    wv = 1;
                end else begin
                    qv = qv - 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit ld, input bit e, input bit u,
                        input logic [15:0] dv);
        rst_n  = r;
        load_n = ld;
        en     = e;
        up     = u;
        d      = dv;
        @(negedge clk);
        chk("tc4",  int'(tc4),  model_tc(m4q,  e, u, 10));
        chk("tc8",  int'(tc8),  model_tc(m8q,  e, u, 200));
        chk("tc16", int'(tc16), model_tc(m16q, e, u, 65536));
        @(posedge clk);
        #1;
        model_step(m4q,  m4w,  r, ld, e, u, int'(dv[3:0]), 10);
        model_step(m8q,  m8w,  r, ld, e, u, int'(dv[7:0]), 200);
        model_step(m16q, m16w, r, ld, e, u, int'(dv),      65536);
        chk("q4",    int'(q4),   m4q);
        chk("wr4",   int'(wr4),  m4w);
        chk("q8",    int'(q8),   m8q);
        chk("wr8",   int'(wr8),  m8w);
        chk("q16",   int'(q16),  m16q);
        chk("wr16",  int'(wr16), m16w);
    endtask

    initial begin
        rst_n   = 1'b0;
        load_n  = 1'b1;
        en      = 1'b0;
        up      = 1'b1;
        d       = '0;
        c_rst_n = 1'b0;

        // Mod-10 vectors: reset, count up through wrap, load, count down, clamp
        vt.push_back('{0, 1, 0, 1, 0, 0, 0});
        for (int i = 1; i <= 11; i++)
            vt.push_back('{1, 1, 1, 1, 0, i % 10, (i >= 10) ? 1 : 0});
        vt.push_back('{1, 0, 0, 1, 4, 4, 0});
        for (int k = 1; k <= 6; k++)
            vt.push_back('{1, 1, 1, 0, 0, (4 - k + 10) % 10, (k >= 5) ? 1 : 0});
        vt.push_back('{1, 0, 0, 0, 13, 9, 0});
        vt.push_back('{1, 0, 1, 1, 13, 9, 0});
        vt.push_back('{1, 0, 1, 0, 5, 5, 0});
        vt.push_back('{1, 1, 0, 1, 0, 5, 0});
        vt.push_back('{1, 1, 1, 1, 0, 6, 0});
        vt.push_back('{1, 1, 1, 0, 0, 5, 0});

        foreach (vt[i]) begin
            step(vt[i].r, vt[i].ld, vt[i].e, vt[i].u, 16'(vt[i].dv));
            chk("vec_q",  int'(q4),  vt[i].exp_q);
            chk("vec_wr", int'(wr4), vt[i].exp_w);
        end

        // Mod-200: reset mid-count overrides a simultaneous load
        step(0, 1, 0, 1, 16'd0);
        for (int i = 0; i < 150; i++) step(1, 1, 1, 1, 16'd0);
        chk("q8_at_150", int'(q8), 150);
        step(0, 0, 1, 1, 16'd77);
        chk("q8_rst_over_load", int'(q8), 0);
        chk("wr8_rst_over_load", int'(wr8), 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 1, 16'd0);
            chk("q8_hold", int'(q8), 0);
            chk("tc8_hold", int'(tc8), 0);
        end

        // Full-range 16-bit modulus: no clamp, wrap from FFFF
        step(1, 0, 0, 1, 16'hFFFF);
        chk("q16_load_ffff", int'(q16), 65535);
        step(1, 1, 1, 1, 16'd0);
        chk("q16_wrap", int'(q16), 0);
        chk("wr16_wrap", int'(wr16), 1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0, 1'($urandom),
                 16'($urandom));
        end

        // Two-digit decade cascade
        rst_n  = 1'b1;
        load_n = 1'b1;
        en     = 1'b0;
        c_rst_n = 1'b0;
        @(posedge clk);
        #1;
        c_rst_n = 1'b1;
        chk("casc_rst", int'(hi_q) * 10 + int'(lo_q), 0);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            chk("casc_hi_tc", int'(hi_tc), ((n - 1) == 99) ? 1 : 0);
            @(posedge clk);
            #1;
            chk("casc_count", int'(hi_q) * 10 + int'(lo_q), n % 100);
            if (n < 10) chk("casc_lo_wr_early", int'(lo_wr), 0);
        end
        chk("casc_lo_wr", int'(lo_wr), 1);
        chk("casc_hi_wr", int'(hi_wr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
